datapath_sequencer: RTL and testbench

- Control stage directly upstream of the register-file/ALU datapath.
- Accepts one command at a time over a valid/ready handshake and expands it into cycle-by-cycle datapath controls: Ctrl, Sel, Wen, WA, RAA, RAB and Op.
- Samples the datapath Flag for compare commands.
- Signals when a register value is presented on OutPort (Op==4 with RAA == register address).

---
 rtl/datapath_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Control stage in front of the register-file/ALU datapath. Accepts one
//   command at a time over a valid/ready handshake and expands it into
//   registered, cycle-by-cycle datapath controls.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while IDLE)
//   cmd_code              0 NOP, 1 LOADN, 2 ALU, 3 OUT, 4 TEST, 5-7 illegal
//   cmd_sel/cmd_count     first InPort byte index / byte count (LOADN)
//   cmd_dst               destination register (LOADN, ALU)
//   cmd_srca/cmd_srcb     source registers
//   cmd_alu               ALU opcode (ALU, TEST)
//   Ctrl                  bit0 = write source (1 InPort byte, 0 ALU result)
//   Sel, Wen, WA          InPort byte select, write enable, write address
//   RAA, RAB, Op          read addresses, ALU opcode (4 = pass RAA out)
//   Flag                  datapath flag, sampled at the end of a TEST cycle
//   out_valid             OutPort currently holds register RAA
//   flag_q                last sampled Flag
//   err                   sticky illegal-command flag
module datapath_sequencer #(
  parameter int unsigned OUT_HOLD  = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_code,
  input  logic [3:0] cmd_sel,
  input  logic [3:0] cmd_count,
  input  logic [3:0] cmd_dst,
  input  logic [3:0] cmd_srca,
  input  logic [3:0] cmd_srcb,
  input  logic [2:0] cmd_alu,
  output logic [7:0] Ctrl,
  output logic [3:0] Sel,
  output logic       Wen,
  output logic [3:0] WA,
  output logic [3:0] RAA,
  output logic [3:0] RAB,
  output logic [2:0] Op,
  input  logic       Flag,
  output logic       out_valid,
  output logic       flag_q,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WB,
    S_OUT,
    S_TEST,
    S_DONE
  } state_t;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_LOADN = 3'd1;
  localparam logic [2:0] CMD_ALU   = 3'd2;
  localparam logic [2:0] CMD_OUT   = 3'd3;
  localparam logic [2:0] CMD_TEST  = 3'd4;
  localparam logic [2:0] OP_PASS   = 3'd4;

  localparam logic [3:0] MAX_BURST_W = 4'(MAX_BURST);
  localparam logic [3:0] HOLD_LAST   = 4'(OUT_HOLD - 1);

  state_t     state_q, state_d;
  logic       ready_q, ready_d;
  logic       ctrl0_q, ctrl0_d;
  logic [3:0] sel_q,   sel_d;
  logic       wen_q,   wen_d;
  logic [3:0] wa_q,    wa_d;
  logic [3:0] raa_q,   raa_d;
  logic [3:0] rab_q,   rab_d;
  logic [2:0] op_q,    op_d;
  logic       ov_q,    ov_d;
  logic       flag_d;
  logic       err_q,   err_d;
  logic [3:0] dst_q,   dst_d;
  // Remaining LOAD cycles or remaining OUT hold cycles, minus one.
  logic [3:0] cnt_q,   cnt_d;
  logic [3:0] burst;

  always_comb begin
    if (cmd_count == 4'd0) begin
      burst = 4'd1;
    end else if (cmd_count > MAX_BURST_W) begin
      burst = MAX_BURST_W;
    end else begin
      burst = cmd_count;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl0_d = ctrl0_q;
    sel_d   = sel_q;
    wen_d   = 1'b0;
    wa_d    = wa_q;
    raa_d   = raa_q;
    rab_d   = rab_q;
    op_d    = op_q;
    ov_d    = 1'b0;
    flag_d  = flag_q;
    err_d   = err_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          ctrl0_d = 1'b0;
          case (cmd_code)
            CMD_NOP: state_d = S_DONE;
            CMD_LOADN: begin
              state_d = S_LOAD;
              ctrl0_d = 1'b1;
              wen_d   = 1'b1;
              sel_d   = cmd_sel & 4'h7;
              wa_d    = cmd_dst;
              op_d    = '0;
              cnt_d   = burst - 4'd1;
            end
            CMD_ALU: begin
              state_d = S_EXEC;
              raa_d   = cmd_srca;
              rab_d   = cmd_srcb;
              op_d    = cmd_alu;
              dst_d   = cmd_dst;
            end
            CMD_OUT: begin
              state_d = S_OUT;
              raa_d   = cmd_srca;
              op_d    = OP_PASS;
              cnt_d   = HOLD_LAST;
              ov_d    = (HOLD_LAST == 4'd0);
            end
            CMD_TEST: begin
              state_d = S_TEST;
              raa_d   = cmd_srca;
              rab_d   = cmd_srcb;
              op_d    = cmd_alu;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          sel_d = (sel_q + 4'd1) & 4'h7;
          wa_d  = wa_q + 4'd1;
          wen_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        wen_d   = 1'b1;
        wa_d    = dst_q;
      end
      S_WB: state_d = S_DONE;
      S_OUT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          // The cycle about to start is the last hold cycle.
          ov_d  = (cnt_q == 4'd1);
        end
      end
      S_TEST: begin
        flag_d  = Flag;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every path into DONE quiets the control strobes; addresses hold.
    if (state_d == S_DONE) begin
      ctrl0_d = 1'b0;
      op_d    = '0;
      wen_d   = 1'b0;
      ov_d    = 1'b0;
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      ctrl0_q <= 1'b0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      wa_q    <= '0;
      raa_q   <= '0;
      rab_q   <= '0;
      op_q    <= '0;
      ov_q    <= 1'b0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ctrl0_q <= ctrl0_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      wa_q    <= wa_d;
      raa_q   <= raa_d;
      rab_q   <= rab_d;
      op_q    <= op_d;
      ov_q    <= ov_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready = ready_q;
  assign Ctrl      = {7'b0, ctrl0_q};
  assign Sel       = sel_q;
  assign Wen       = wen_q;
  assign WA        = wa_q;
  assign RAA       = raa_q;
  assign RAB       = rab_q;
  assign Op        = op_q;
  assign out_valid = ov_q;
  assign err       = err_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: hand-written sequences for reset and
// multi-cycle corner cases, then a table of commands checked in a loop.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_code = '0;
  logic [3:0] cmd_sel = '0, cmd_count = '0, cmd_dst = '0;
  logic [3:0] cmd_srca = '0, cmd_srcb = '0;
  logic [2:0] cmd_alu = '0;
  logic [7:0] Ctrl;
  logic [3:0] Sel, WA, RAA, RAB;
  logic       Wen, out_valid, flag_q, err;
  logic [2:0] Op;
  logic       Flag = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(.OUT_HOLD(2), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_sel(cmd_sel), .cmd_count(cmd_count),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_alu(cmd_alu),
    .Ctrl(Ctrl), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB),
    .Op(Op), .Flag(Flag), .out_valid(out_valid), .flag_q(flag_q), .err(err)
  );

  // Minimal datapath: InPort bytes, register file, OutPort pass-through.
  logic [7:0] inport [8];
  logic [7:0] regs [16];
  logic [7:0] outport;

  always @(posedge clk) begin
    if (Wen) regs[WA] <= Ctrl[0] ? inport[Sel[2:0]] : 8'hEE;
  end
  assign outport = (Op == 3'd4) ? regs[RAA] : 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic issue(input int code, input int sel, input int count,
                       input int dst, input int srca, input int srcb,
                       input int alu);
    wait_ready("issue");
    cmd_code  = 3'(code);
    cmd_sel   = 4'(sel);
    cmd_count = 4'(count);
    cmd_dst   = 4'(dst);
    cmd_srca  = 4'(srca);
    cmd_srcb  = 4'(srcb);
    cmd_alu   = 3'(alu);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    string name;
    int code, sel, count, dst, srca, srcb, alu, flag;
    int busy, wens, ovs, wen0, ctrl0, op0, raa0, rab0, sel0, wa0;
    int kind;  // 0 none, 1 load addresses, 2 RAA only, 3 RAA and RAB
    int err, flg;
  } vec_t;

  function automatic vec_t mk(input string name,
      input int code, input int sel, input int count, input int dst,
      input int srca, input int srcb, input int alu, input int flag,
      input int busy, input int wens, input int ovs, input int wen0,
      input int ctrl0, input int op0, input int raa0, input int rab0,
      input int sel0, input int wa0, input int kind, input int e,
      input int flg);
    vec_t v;
    v.name = name; v.code = code; v.sel = sel; v.count = count; v.dst = dst;
    v.srca = srca; v.srcb = srcb; v.alu = alu; v.flag = flag;
    v.busy = busy; v.wens = wens; v.ovs = ovs; v.wen0 = wen0;
    v.ctrl0 = ctrl0; v.op0 = op0; v.raa0 = raa0; v.rab0 = rab0;
    v.sel0 = sel0; v.wa0 = wa0; v.kind = kind; v.err = e; v.flg = flg;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_sel [4];
    int exp_wa [4];
    exp_sel = '{6, 7, 0, 1};
    exp_wa  = '{14, 15, 0, 1};
    for (int i = 0; i < 8; i++) inport[i] = 8'(8'h10 + i);
    inport[3] = 8'h5A;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;

    //     name        code sel cnt dst sa sb alu flg | busy wens ovs wen0 ctl op raa rab sel wa kind err flg
    vecs[0]  = mk("nop",    0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk("ld_c0",  1, 2, 0, 3, 0, 0, 0, 0,   2, 1, 0, 1, 1, 0, 0, 0, 2, 3, 1, 0, 0);
    vecs[2]  = mk("ld_c15", 1, 1, 15, 0, 0, 0, 0, 0,  9, 8, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    vecs[3]  = mk("ld_s13", 1, 13, 2, 15, 0, 0, 0, 0, 3, 2, 0, 1, 1, 0, 0, 0, 5, 15, 1, 0, 0);
    vecs[4]  = mk("alu2",   2, 0, 0, 9, 3, 5, 2, 0,   3, 1, 0, 0, 0, 2, 3, 5, 0, 0, 3, 0, 0);
    vecs[5]  = mk("alu4",   2, 0, 0, 7, 1, 2, 4, 0,   3, 1, 0, 0, 0, 4, 1, 2, 0, 0, 3, 0, 0);
    vecs[6]  = mk("out5",   3, 0, 0, 0, 5, 0, 0, 0,   3, 0, 1, 0, 0, 4, 5, 0, 0, 0, 2, 0, 0);
    vecs[7]  = mk("test_f1", 4, 0, 0, 0, 2, 4, 5, 1,  2, 0, 0, 0, 0, 5, 2, 4, 0, 0, 3, 0, 1);
    vecs[8]  = mk("test_f0", 4, 0, 0, 0, 6, 7, 1, 0,  2, 0, 0, 0, 0, 1, 6, 7, 0, 0, 3, 0, 0);
    vecs[9]  = mk("ill6",   6, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk("ill7",   7, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mk("nop_err", 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset state
    #12;
    check("rst_wen", int'(Wen), 0);
    check("rst_ctrl", int'(Ctrl), 0);
    check("rst_op", int'(Op), 0);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_err", int'(err), 0);
    check("rst_flag", int'(flag_q), 0);
    #5 rst_n = 1'b1;
    step();
    check("post_rst_ready", int'(cmd_ready), 1);

    // Reset during the 2nd cycle of a 4-byte LOADN
    issue(1, 0, 4, 0, 0, 0, 0);
    check("midrst_c1_wen", int'(Wen), 1);
    step();
    check("midrst_c2_wen", int'(Wen), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_wen", int'(Wen), 0);
    check("midrst_ctrl", int'(Ctrl), 0);
    check("midrst_wa", int'(WA), 0);
    check("midrst_sel", int'(Sel), 0);
    #2 rst_n = 1'b1;
    step();
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_after_wen", int'(Wen), 0);
    step();
    check("midrst_after2_wen", int'(Wen), 0);

    // LOADN sel=6 count=4 dst=14: Sel and WA wrap
    issue(1, 6, 4, 14, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ld4_sel%0d", k), int'(Sel), exp_sel[k]);
      check($sformatf("ld4_wa%0d", k), int'(WA), exp_wa[k]);
      check($sformatf("ld4_wen%0d", k), int'(Wen), 1);
      check($sformatf("ld4_ctrl%0d", k), int'(Ctrl), 1);
      step();
    end
    check("ld4_done_wen", int'(Wen), 0);
    check("ld4_done_ready", int'(cmd_ready), 0);
    step();
    check("ld4_idle_ready", int'(cmd_ready), 1);

    // ALU 3,5 -> 9 with opcode 2
    issue(2, 0, 0, 9, 3, 5, 2);
    check("alu_exec_wen", int'(Wen), 0);
    check("alu_exec_op", int'(Op), 2);
    step();
    check("alu_wb_wen", int'(Wen), 1);
    check("alu_wb_wa", int'(WA), 9);
    check("alu_wb_op", int'(Op), 2);
    check("alu_wb_ctrl", int'(Ctrl), 0);
    check("alu_wb_raa", int'(RAA), 3);
    check("alu_wb_rab", int'(RAB), 5);
    step();
    check("alu_done_ready", int'(cmd_ready), 0);
    step();
    check("alu_idle_ready", int'(cmd_ready), 1);

    // LOADN reg5 <= InPort[3] (0x5A), then OUT reg5
    issue(1, 3, 1, 5, 0, 0, 0);
    issue(3, 0, 0, 0, 5, 0, 0);
    check("out_c1_op", int'(Op), 4);
    check("out_c1_raa", int'(RAA), 5);
    check("out_c1_ov", int'(out_valid), 0);
    check("out_c1_wen", int'(Wen), 0);
    step();
    check("out_c2_op", int'(Op), 4);
    check("out_c2_raa", int'(RAA), 5);
    check("out_c2_ov", int'(out_valid), 1);
    check("out_c2_wen", int'(Wen), 0);
    check("out_c2_port", int'(outport), 8'h5A);
    step();
    check("out_done_ov", int'(out_valid), 0);
    check("out_done_op", int'(Op), 0);

    // Table-driven commands
    for (int i = 0; i < 12; i++) begin
      int busy, wens, ovs, viol;
      int wen0, ctrl0, op0, raa0, rab0, sel0, wa0;
      wait_ready(vecs[i].name);
      Flag = vecs[i].flag[0];
      issue(vecs[i].code, vecs[i].sel, vecs[i].count, vecs[i].dst,
            vecs[i].srca, vecs[i].srcb, vecs[i].alu);
      wen0 = int'(Wen); ctrl0 = int'(Ctrl); op0 = int'(Op);
      raa0 = int'(RAA); rab0 = int'(RAB); sel0 = int'(Sel); wa0 = int'(WA);
      busy = 0; wens = 0; ovs = 0; viol = 0;
      for (int c = 0; c < 20; c++) begin
        if (cmd_ready) break;
        busy++;
        if (Wen) wens++;
        if (out_valid) ovs++;
        if (Wen && out_valid) viol++;
        step();
      end
      check({vecs[i].name, "_busy"}, busy, vecs[i].busy);
      check({vecs[i].name, "_wens"}, wens, vecs[i].wens);
      check({vecs[i].name, "_ovs"}, ovs, vecs[i].ovs);
      check({vecs[i].name, "_wen_ov_overlap"}, viol, 0);
      check({vecs[i].name, "_wen0"}, wen0, vecs[i].wen0);
      check({vecs[i].name, "_ctrl0"}, ctrl0, vecs[i].ctrl0);
      if (vecs[i].kind >= 2) begin
        check({vecs[i].name, "_op0"}, op0, vecs[i].op0);
        check({vecs[i].name, "_raa0"}, raa0, vecs[i].raa0);
      end
      if (vecs[i].kind == 3) check({vecs[i].name, "_rab0"}, rab0, vecs[i].rab0);
      if (vecs[i].kind == 1) begin
        check({vecs[i].name, "_sel0"}, sel0, vecs[i].sel0);
        check({vecs[i].name, "_wa0"}, wa0, vecs[i].wa0);
      end
      check({vecs[i].name, "_err"}, int'(err), vecs[i].err);
      check({vecs[i].name, "_flag_q"}, int'(flag_q), vecs[i].flg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
